// File: rtl/fsk_goertzel_demodulator_pkg.sv
// Shared constants and types for the two-tone Goertzel FSK demodulator.
package fsk_demod_pkg;

    // Fraction width of the Q2.14 Goertzel coefficients.
    localparam int Q_FRAC = 14;

    // ADC sample width (signed two's complement).
    localparam int ADC_W = 14;

    // 2*cos(2*pi*k/64) in Q2.14 for bins k=2 and k=10.
    localparam int COEFF_K2  = 32138;
    localparam int COEFF_K10 = 18205;

    // Power evaluation sequence, one cycle per state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL1   = 3'd1,
        MUL2   = 3'd2,
        SUM    = 3'd3,
        DECIDE = 3'd4
    } pwr_state_t;

endpackage

// File: rtl/fsk_goertzel_demodulator_if.sv
// Sample input and decision output bundle of the FSK demodulator.
interface fsk_demod_if
    import fsk_demod_pkg::*;
();
    // Handshake: a sample is consumed on every rising clock edge where
    // i_sample_valid is high; there is no back-pressure (no ready), so the
    // source may hold valid high every cycle or leave gaps of any length.
    // o_bit_valid is a one-cycle pulse marking a fresh o_bit/o_carrier/power
    // set; those outputs hold their values between pulses.
    logic signed [ADC_W-1:0] is14_adc_data;
    logic                    i_sample_valid;
    logic                    o_bit;
    logic                    o_bit_valid;
    logic                    o_carrier;
    logic [31:0]             o32_power_f0;
    logic [31:0]             o32_power_f1;
    pwr_state_t              dbg_state;

    // Demodulator side.
    modport slave (
        input  is14_adc_data, i_sample_valid,
        output o_bit, o_bit_valid, o_carrier, o32_power_f0, o32_power_f1, dbg_state
    );

    // Sample source / bit consumer side.
    modport master (
        output is14_adc_data, i_sample_valid,
        input  o_bit, o_bit_valid, o_carrier, o32_power_f0, o32_power_f1, dbg_state
    );

endinterface

// File: rtl/fsk_goertzel_demodulator_goertzel_bin.sv
// One Goertzel resonator: s1/s2 recursion, block-end snapshot and clear.
module goertzel_bin
    import fsk_demod_pkg::*;
#(
    parameter int COEFF   = COEFF_K2,
    parameter int STATE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [ADC_W-1:0]   x,
    input  logic                      sample_en,
    input  logic                      block_end,
    output logic signed [STATE_W-1:0] snap_s1,
    output logic signed [STATE_W-1:0] snap_s2
);
    localparam int CW = STATE_W + 16;
    localparam logic signed [CW-1:0] COEFF_W = CW'(COEFF);

    logic signed [STATE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic signed [STATE_W-1:0] snap_s1_q, snap_s1_d, snap_s2_q, snap_s2_d;
    logic signed [CW-1:0]      s1_w;
    logic signed [STATE_W-1:0] x_w;
    logic signed [STATE_W-1:0] s0;

    assign s1_w = {{16{s1_q[STATE_W-1]}}, s1_q};
    assign x_w  = {{(STATE_W-ADC_W){x[ADC_W-1]}}, x};
    // Full-width product, flooring shift, then wrap to the state width.
    assign s0   = x_w + STATE_W'((COEFF_W * s1_w) >>> Q_FRAC) - s2_q;

    // Next state: advance on each accepted sample; at block end hand the
    // final state to the snapshot and restart from zero.
    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        snap_s1_d = snap_s1_q;
        snap_s2_d = snap_s2_q;
        if (sample_en) begin
            if (block_end) begin
                snap_s1_d = s0;
                snap_s2_d = s1_q;
                s1_d      = '0;
                s2_d      = '0;
            end else begin
                s1_d = s0;
                s2_d = s1_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            snap_s1_q <= '0;
            snap_s2_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            snap_s1_q <= snap_s1_d;
            snap_s2_q <= snap_s2_d;
        end
    end

    assign snap_s1 = snap_s1_q;
    assign snap_s2 = snap_s2_q;

endmodule

// File: rtl/fsk_goertzel_demodulator.sv
// Two-bin Goertzel FSK demodulator: block counter, power FSM and decision.
module fsk_goertzel_demodulator
    import fsk_demod_pkg::*;
#(
    parameter int N_BLOCK   = 64,
    parameter int STATE_W   = 32,
    parameter int COEFF_F0  = COEFF_K2,
    parameter int COEFF_F1  = COEFF_K10,
    parameter int PWR_SHIFT = 24,
    parameter int MIN_POWER = 1024
) (
    input  logic  clk100mhz,
    input  logic  rst,
    fsk_demod_if.slave bus
);
    localparam int CNT_W = $clog2(N_BLOCK);
    localparam int CW    = STATE_W + 16;
    localparam int PW    = 2 * STATE_W;
    localparam logic signed [CW-1:0] COEFF_W0 = CW'(COEFF_F0);
    localparam logic signed [CW-1:0] COEFF_W1 = CW'(COEFF_F1);
    localparam logic [PW-1:0]        PWR_MAX  = PW'(64'hFFFF_FFFF);
    localparam logic [31:0]          MIN_P    = 32'(MIN_POWER);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_BLOCK - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             block_end;

    logic signed [STATE_W-1:0] snap_s1 [2];
    logic signed [STATE_W-1:0] snap_s2 [2];
    logic signed [CW-1:0]      coeff_w [2];
    logic signed [CW-1:0]      s1_cw   [2];
    logic signed [PW-1:0]      s1_x    [2];
    logic signed [PW-1:0]      s2_x    [2];
    logic signed [PW-1:0]      c1_x    [2];
    logic signed [PW-1:0]      sum     [2];
    logic [PW-1:0]             shifted [2];
    logic [31:0]               pout    [2];

    logic signed [PW-1:0] pa_q [2], pa_d [2];
    logic signed [PW-1:0] pb_q [2], pb_d [2];
    logic signed [PW-1:0] pc_q [2], pc_d [2];
    logic signed [CW-1:0] c1_q [2], c1_d [2];
    logic [PW-1:0]        pw_q [2], pw_d [2];

    pwr_state_t  state_q, state_d;
    logic        bit_q, bit_d;
    logic        bit_valid_q, bit_valid_d;
    logic        carrier_q, carrier_d;
    logic [31:0] power_f0_q, power_f0_d;
    logic [31:0] power_f1_q, power_f1_d;

    // Sample counter: advances per accepted sample, wraps after the last one.
    always_comb begin
        cnt_d     = cnt_q;
        block_end = bus.i_sample_valid && (cnt_q == CNT_LAST);
        if (bus.i_sample_valid) begin
            cnt_d = block_end ? '0 : cnt_q + 1'b1;
        end
    end

    goertzel_bin #(.COEFF(COEFF_F0), .STATE_W(STATE_W)) u_bin_f0 (
        .clk       (clk100mhz),
        .rst       (rst),
        .x         (bus.is14_adc_data),
        .sample_en (bus.i_sample_valid),
        .block_end (block_end),
        .snap_s1   (snap_s1[0]),
        .snap_s2   (snap_s2[0])
    );

    goertzel_bin #(.COEFF(COEFF_F1), .STATE_W(STATE_W)) u_bin_f1 (
        .clk       (clk100mhz),
        .rst       (rst),
        .x         (bus.is14_adc_data),
        .sample_en (bus.i_sample_valid),
        .block_end (block_end),
        .snap_s1   (snap_s1[1]),
        .snap_s2   (snap_s2[1])
    );

    // Per-bin operand extension and the clamp/shift/saturate of the power.
    for (genvar b = 0; b < 2; b++) begin : g_bin
        assign coeff_w[b] = (b == 0) ? COEFF_W0 : COEFF_W1;
        assign s1_cw[b]   = {{16{snap_s1[b][STATE_W-1]}}, snap_s1[b]};
        assign s1_x[b]    = {{STATE_W{snap_s1[b][STATE_W-1]}}, snap_s1[b]};
        assign s2_x[b]    = {{STATE_W{snap_s2[b][STATE_W-1]}}, snap_s2[b]};
        assign c1_x[b]    = {{(PW-CW){c1_q[b][CW-1]}}, c1_q[b]};
        assign sum[b]     = pa_q[b] + pb_q[b] - pc_q[b];
        assign shifted[b] = pw_q[b] >> PWR_SHIFT;
        assign pout[b]    = (shifted[b] > PWR_MAX) ? 32'hFFFF_FFFF : shifted[b][31:0];
    end

    // Power FSM next state: both bins evaluated in lockstep from the snapshot.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        carrier_d   = carrier_q;
        power_f0_d  = power_f0_q;
        power_f1_d  = power_f1_q;
        for (int b = 0; b < 2; b++) begin
            pa_d[b] = pa_q[b];
            pb_d[b] = pb_q[b];
            pc_d[b] = pc_q[b];
            c1_d[b] = c1_q[b];
            pw_d[b] = pw_q[b];
        end
        case (state_q)
            IDLE: begin
                if (block_end) state_d = MUL1;
            end
            MUL1: begin
                for (int b = 0; b < 2; b++) begin
                    pa_d[b] = s1_x[b] * s1_x[b];
                    pb_d[b] = s2_x[b] * s2_x[b];
                    c1_d[b] = (coeff_w[b] * s1_cw[b]) >>> Q_FRAC;
                end
                state_d = MUL2;
            end
            MUL2: begin
                for (int b = 0; b < 2; b++) begin
                    pc_d[b] = c1_x[b] * s2_x[b];
                end
                state_d = SUM;
            end
            SUM: begin
                for (int b = 0; b < 2; b++) begin
                    pw_d[b] = sum[b][PW-1] ? '0 : sum[b];
                end
                state_d = DECIDE;
            end
            DECIDE: begin
                power_f0_d  = pout[0];
                power_f1_d  = pout[1];
                bit_d       = pout[1] > pout[0];
                carrier_d   = (pout[0] >= MIN_P) || (pout[1] >= MIN_P);
                bit_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            carrier_q   <= 1'b0;
            power_f0_q  <= '0;
            power_f1_q  <= '0;
            for (int b = 0; b < 2; b++) begin
                pa_q[b] <= '0;
                pb_q[b] <= '0;
                pc_q[b] <= '0;
                c1_q[b] <= '0;
                pw_q[b] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            carrier_q   <= carrier_d;
            power_f0_q  <= power_f0_d;
            power_f1_q  <= power_f1_d;
            for (int b = 0; b < 2; b++) begin
                pa_q[b] <= pa_d[b];
                pb_q[b] <= pb_d[b];
                pc_q[b] <= pc_d[b];
                c1_q[b] <= c1_d[b];
                pw_q[b] <= pw_d[b];
            end
        end
    end

    assign bus.o_bit        = bit_q;
    assign bus.o_bit_valid  = bit_valid_q;
    assign bus.o_carrier    = carrier_q;
    assign bus.o32_power_f0 = power_f0_q;
    assign bus.o32_power_f1 = power_f1_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_fsk_goertzel_demodulator.sv
// Directed bench for the Goertzel FSK demodulator.
module tb_fsk_goertzel_demodulator;
    import fsk_demod_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic        b;
        logic        car;
        logic [31:0] p0;
        logic [31:0] p1;
    } rec_t;

    logic clk100mhz = 1'b0;
    logic rst       = 1'b1;
    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;
    int   blk_x [64];
    int   last_first_acc = 0;
    rec_t pulse_q [$];
    rec_t exp_q   [$];

    fsk_demod_if bus ();

    fsk_goertzel_demodulator dut (
        .clk100mhz (clk100mhz),
        .rst       (rst),
        .bus       (bus.slave)
    );

    // Clock / cycle counter
    always #5 clk100mhz = ~clk100mhz;
    always @(posedge clk100mhz) cyc <= cyc + 1;

    // Capture every decision pulse away from the active edge
    always @(negedge clk100mhz) begin
        if (bus.o_bit_valid === 1'b1)
            pulse_q.push_back({32'(cyc), bus.o_bit, bus.o_carrier, bus.o32_power_f0, bus.o32_power_f1});
    end

    // Reference Goertzel power of the current blk_x for one coefficient
    function automatic logic [31:0] model_pwr(int coeff);
        int s1 = 0, s2 = 0, s0;
        longint c, p, q;
        for (int n = 0; n < 64; n++) begin
            c  = (longint'(coeff) * longint'(s1)) >>> 14;
            s0 = int'(longint'(blk_x[n]) + c - longint'(s2));
            s2 = s1;
            s1 = s0;
        end
        c = (longint'(coeff) * longint'(s1)) >>> 14;
        p = longint'(s1) * longint'(s1) + longint'(s2) * longint'(s2) - c * longint'(s2);
        if (p < 0) p = 0;
        q = p >>> 24;
        return (q > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(q);
    endfunction

    function automatic string fmt(rec_t r);
        return $sformatf("cyc=%0d bit=%0b car=%0b p0=%0d p1=%0d", r.cyc, r.b, r.car, r.p0, r.p1);
    endfunction

    // Driver tasks
    task automatic fill_tone(int k, int amp);
        for (int n = 0; n < 64; n++)
            blk_x[n] = (amp == 0) ? 0 : int'(amp * $cos(2.0 * 3.141592653589793 * k * n / 64.0));
    endtask

    task automatic step(int x, logic v);
        bus.is14_adc_data  = 14'(x);
        bus.i_sample_valid = v;
        @(posedge clk100mhz);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 1'b0);
    endtask

    // Send the first cnt samples of blk_x, gap idle cycles after each one
    task automatic send_block(int gap, int cnt);
        rec_t e;
        for (int n = 0; n < cnt; n++) begin
            step(blk_x[n], 1'b1);
            if (n == 0) last_first_acc = cyc;
            if (n == 63) begin
                e.p0  = model_pwr(COEFF_K2);
                e.p1  = model_pwr(COEFF_K10);
                e.b   = e.p1 > e.p0;
                e.car = (e.p0 >= 32'd1024) || (e.p1 >= 32'd1024);
                e.cyc = 32'(cyc + 4);
                exp_q.push_back(e);
            end
            idle(gap);
        end
    endtask

    task automatic take(output rec_t r, output logic ok);
        ok = pulse_q.size() > 0;
        r  = ok ? pulse_q.pop_front() : '0;
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        total += 6;
        if (bus.o_bit_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_bit_valid); end
        if (bus.o_bit !== 1'b0) begin bad++; $display("FAIL reset_bit: got %b want 0", bus.o_bit); end
        if (bus.o_carrier !== 1'b0) begin bad++; $display("FAIL reset_carrier: got %b want 0", bus.o_carrier); end
        if (bus.o32_power_f0 !== 32'd0) begin bad++; $display("FAIL reset_p0: got %0d want 0", bus.o32_power_f0); end
        if (bus.o32_power_f1 !== 32'd0) begin bad++; $display("FAIL reset_p1: got %0d want 0", bus.o32_power_f1); end
        if (bus.dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
    endtask

    task automatic test_zero_input();
        rec_t got, want, first;
        logic ok;
        int   first_acc = 0;
        fill_tone(0, 0);
        for (int i = 0; i < 3; i++) begin
            send_block(0, 64);
            if (i == 0) first_acc = last_first_acc;
        end
        idle(8);
        first = '0;
        for (int i = 0; i < 3; i++) begin
            take(got, ok);
            want = exp_q.pop_front();
            want.p0 = 32'd0; want.p1 = 32'd0; want.b = 1'b0; want.car = 1'b0;
            if (i == 0) first = got;
            total++;
            if (!ok || got !== want) begin bad++; $display("FAIL zero blk%0d: got %s want %s", i, fmt(got), fmt(want)); end
            if (i == 1) begin
                total++;
                if (int'(got.cyc - first.cyc) !== 64) begin bad++; $display("FAIL zero_spacing: got %0d want 64", got.cyc - first.cyc); end
            end
        end
        total++;
        if (int'(first.cyc) - first_acc !== 67) begin bad++; $display("FAIL zero_first_latency: got %0d want 67", int'(first.cyc) - first_acc); end
        total++;
        if (pulse_q.size() != 0) begin bad++; $display("FAIL zero_extra: got %0d extra pulses want 0", pulse_q.size()); pulse_q.delete(); end
    endtask

    task automatic test_tone_f0();
        rec_t got, want;
        logic ok;
        // Amplitude 8000 keeps the bin power well above MIN_POWER
        fill_tone(2, 8000);
        send_block(0, 64);
        send_block(0, 64);
        // Half amplitude lands close to the carrier threshold
        fill_tone(2, 4000);
        send_block(0, 64);
        idle(8);
        for (int i = 0; i < 3; i++) begin
            take(got, ok);
            want = exp_q.pop_front();
            total++;
            if (!ok || got !== want) begin bad++; $display("FAIL tone_f0 blk%0d: got %s want %s", i, fmt(got), fmt(want)); end
            if (i < 2) begin
                total += 3;
                if (got.b !== 1'b0) begin bad++; $display("FAIL tone_f0_bit blk%0d: got %b want 0", i, got.b); end
                if (got.car !== 1'b1) begin bad++; $display("FAIL tone_f0_carrier blk%0d: got %b want 1", i, got.car); end
                if (!(longint'(got.p0) > 10 * longint'(got.p1))) begin
                    bad++; $display("FAIL tone_f0_ratio blk%0d: got p0=%0d p1=%0d want p0>10*p1", i, got.p0, got.p1);
                end
            end
        end
        total++;
        if (bus.o32_power_f0 !== want.p0) begin bad++; $display("FAIL tone_f0_hold: got %0d want %0d", bus.o32_power_f0, want.p0); end
        total++;
        if (pulse_q.size() != 0) begin bad++; $display("FAIL tone_f0_extra: got %0d want 0", pulse_q.size()); pulse_q.delete(); end
    endtask

    task automatic test_tone_f1();
        rec_t got, want;
        logic ok;
        fill_tone(10, 8000);
        send_block(0, 64);
        send_block(0, 64);
        idle(8);
        for (int i = 0; i < 2; i++) begin
            take(got, ok);
            want = exp_q.pop_front();
            total += 4;
            if (!ok || got !== want) begin bad++; $display("FAIL tone_f1 blk%0d: got %s want %s", i, fmt(got), fmt(want)); end
            if (got.b !== 1'b1) begin bad++; $display("FAIL tone_f1_bit blk%0d: got %b want 1", i, got.b); end
            if (got.car !== 1'b1) begin bad++; $display("FAIL tone_f1_carrier blk%0d: got %b want 1", i, got.car); end
            if (!(longint'(got.p1) > 10 * longint'(got.p0))) begin
                bad++; $display("FAIL tone_f1_ratio blk%0d: got p0=%0d p1=%0d want p1>10*p0", i, got.p0, got.p1);
            end
        end
        total++;
        if (pulse_q.size() != 0) begin bad++; $display("FAIL tone_f1_extra: got %0d want 0", pulse_q.size()); pulse_q.delete(); end
    endtask

    task automatic test_back_to_back();
        rec_t got, want;
        logic ok;
        logic [3:0] want_bits;
        want_bits = 4'b1100;
        fill_tone(2, 8000);
        send_block(0, 64);
        send_block(0, 64);
        fill_tone(10, 8000);
        send_block(0, 64);
        send_block(0, 64);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            take(got, ok);
            want = exp_q.pop_front();
            total += 2;
            if (!ok || got !== want) begin bad++; $display("FAIL b2b blk%0d: got %s want %s", i, fmt(got), fmt(want)); end
            if (got.b !== want_bits[i]) begin bad++; $display("FAIL b2b_bit blk%0d: got %b want %b", i, got.b, want_bits[i]); end
        end
        total++;
        if (pulse_q.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d want 0", pulse_q.size()); pulse_q.delete(); end
    endtask

    task automatic test_sparse_valid();
        rec_t got, want;
        logic ok;
        fill_tone(10, 8000);
        send_block(2, 64);
        idle(8);
        take(got, ok);
        want = exp_q.pop_front();
        total += 2;
        if (!ok || got !== want) begin bad++; $display("FAIL sparse: got %s want %s", fmt(got), fmt(want)); end
        if (got.b !== 1'b1) begin bad++; $display("FAIL sparse_bit: got %b want 1", got.b); end
        total++;
        if (pulse_q.size() != 0) begin bad++; $display("FAIL sparse_extra: got %0d want 0", pulse_q.size()); pulse_q.delete(); end
    endtask

    task automatic test_reset_mid();
        rec_t got, want;
        logic ok;
        fill_tone(10, 8000);
        send_block(0, 40);
        rst = 1'b1;
        step(0, 1'b0);
        rst = 1'b0;
        total += 5;
        if (bus.o_bit !== 1'b0) begin bad++; $display("FAIL midrst_bit: got %b want 0", bus.o_bit); end
        if (bus.o_carrier !== 1'b0) begin bad++; $display("FAIL midrst_carrier: got %b want 0", bus.o_carrier); end
        if (bus.o32_power_f1 !== 32'd0) begin bad++; $display("FAIL midrst_p1: got %0d want 0", bus.o32_power_f1); end
        if (bus.o32_power_f0 !== 32'd0) begin bad++; $display("FAIL midrst_p0: got %0d want 0", bus.o32_power_f0); end
        if (bus.dbg_state !== IDLE) begin bad++; $display("FAIL midrst_state: got %0d want %0d", bus.dbg_state, IDLE); end
        send_block(0, 64);
        idle(8);
        take(got, ok);
        want = exp_q.pop_front();
        total++;
        if (!ok || got !== want) begin bad++; $display("FAIL midrst_block: got %s want %s", fmt(got), fmt(want)); end
        // Reset while the FSM is in SUM must drop that block's decision
        send_block(0, 64);
        void'(exp_q.pop_back());
        idle(2);
        rst = 1'b1;
        step(0, 1'b0);
        rst = 1'b0;
        idle(8);
        total += 2;
        if (pulse_q.size() != 0) begin bad++; $display("FAIL fsmrst_pulse: got %0d pulses want 0", pulse_q.size()); pulse_q.delete(); end
        if (bus.o32_power_f1 !== 32'd0) begin bad++; $display("FAIL fsmrst_p1: got %0d want 0", bus.o32_power_f1); end
    endtask

    initial begin
        bus.is14_adc_data  = '0;
        bus.i_sample_valid = 1'b0;
        test_reset();
        test_zero_input();
        test_tone_f0();
        test_tone_f1();
        test_back_to_back();
        test_sparse_valid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
